// File: rtl/baud_pkg.sv
// rtl/baud_pkg.sv - shared constants and divisor type for the fractional baud generator
package baud_pkg;

  localparam int DIV_W_DEF        = 16;
  localparam int FRAC_W_DEF       = 4;
  localparam int OSR_DEF          = 16;
  localparam int DEF_DIV_INT_DEF  = 27;
  localparam int DEF_DIV_FRAC_DEF = 2;

  // Smallest usable period; keeps oTick from ever being high two cycles running.
  localparam int MIN_DIV = 2;

  typedef struct packed {
    logic [DIV_W_DEF-1:0]  div_int;
    logic [FRAC_W_DEF-1:0] div_frac;
  } divisor_t;

endpackage

// File: rtl/baud_gen_frac_if.sv
// rtl/baud_gen_frac_if.sv - control and tick signals of the fractional baud generator
interface baud_gen_frac_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
);

  logic              iEn;
  logic              iLoad;
  logic [DIV_W-1:0]  iDivInt;
  logic [FRAC_W-1:0] iDivFrac;
  logic              iSync;
  logic              oTick;
  logic              oBitTick;

  modport master (
    output iEn, iLoad, iDivInt, iDivFrac, iSync,
    input  oTick, oBitTick
  );

  modport slave (
    input  iEn, iLoad, iDivInt, iDivFrac, iSync,
    output oTick, oBitTick
  );

endinterface

// File: rtl/baud_gen_frac.sv
// rtl/baud_gen_frac.sv - fractional oversample/bit tick generator with shadowed divisor reload and phase resync
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int DIV_W        = DIV_W_DEF,
  parameter int FRAC_W       = FRAC_W_DEF,
  parameter int OSR          = OSR_DEF,
  parameter int DEF_DIV_INT  = DEF_DIV_INT_DEF,
  parameter int DEF_DIV_FRAC = DEF_DIV_FRAC_DEF
) (
  input logic            clk,
  input logic            reset,
  baud_gen_frac_if.slave bus
);

  localparam int OSR_W = (OSR > 1) ? $clog2(OSR) : 1;

  logic [DIV_W:0]    cnt;
  logic [FRAC_W-1:0] acc;
  logic [OSR_W-1:0]  osr_cnt;
  logic [DIV_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [DIV_W-1:0]  sh_int;
  logic [FRAC_W-1:0] sh_frac;
  logic              pending;
  logic              tick_q;
  logic              bit_q;

  logic              sync_go;
  logic              bound;
  logic [DIV_W-1:0]  sel_int;
  logic [FRAC_W-1:0] sel_frac;
  logic [DIV_W-1:0]  new_int;
  logic [FRAC_W:0]   sum;

  // Divisor for the period about to start: a same-cycle load only wins on a resync,
  // otherwise a pending shadow is applied, otherwise the active divisor is kept.
  always_comb begin
    sync_go  = bus.iEn & bus.iSync;
    bound    = bus.iEn & ~bus.iSync & (cnt == '0);
    sel_int  = act_int;
    sel_frac = act_frac;
    if (sync_go && bus.iLoad) begin
      sel_int  = bus.iDivInt;
      sel_frac = bus.iDivFrac;
    end else if (pending) begin
      sel_int  = sh_int;
      sel_frac = sh_frac;
    end
    new_int = (sel_int < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : sel_int;
    sum     = {1'b0, acc} + {1'b0, sel_frac};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= (DIV_W+1)'(DEF_DIV_INT - 1);
      acc      <= '0;
      osr_cnt  <= '0;
      act_int  <= DIV_W'(DEF_DIV_INT);
      act_frac <= FRAC_W'(DEF_DIV_FRAC);
      sh_int   <= DIV_W'(DEF_DIV_INT);
      sh_frac  <= FRAC_W'(DEF_DIV_FRAC);
      pending  <= 1'b0;
      tick_q   <= 1'b0;
      bit_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      bit_q  <= 1'b0;

      if (bus.iLoad) begin
        sh_int  <= bus.iDivInt;
        sh_frac <= bus.iDivFrac;
      end

      if (sync_go) begin
        pending <= 1'b0;
      end else if (bus.iLoad) begin
        pending <= 1'b1;
      end else if (bound) begin
        pending <= 1'b0;
      end

      if (sync_go) begin
        cnt      <= {1'b0, new_int} - (DIV_W+1)'(1);
        acc      <= '0;
        osr_cnt  <= '0;
        act_int  <= new_int;
        act_frac <= sel_frac;
      end else if (bound) begin
        // The fractional carry stretches this period by one cycle.
        cnt      <= {1'b0, new_int} + {{DIV_W{1'b0}}, sum[FRAC_W]} - (DIV_W+1)'(1);
        acc      <= sum[FRAC_W-1:0];
        act_int  <= new_int;
        act_frac <= sel_frac;
        tick_q   <= 1'b1;
        bit_q    <= (osr_cnt == OSR_W'(OSR - 1));
        osr_cnt  <= (osr_cnt == OSR_W'(OSR - 1)) ? '0 : osr_cnt + OSR_W'(1);
      end else if (bus.iEn) begin
        cnt <= cnt - (DIV_W+1)'(1);
      end
    end
  end

  assign bus.oTick    = tick_q;
  assign bus.oBitTick = bit_q;

endmodule
